// File: rtl/wave_fetch_request_arbiter_if.sv
// -----------------------------------------------------------------------------
// wave_fetch_request_arbiter_if
//
// Purpose: valid/ack handshake between the wavefront fetch request arbiter and
//          the instruction fetch unit.
//
// Signals:
//   fetch_req_valid  arbiter -> fetch  request presented
//   fetch_req_wfid   arbiter -> fetch  wavefront id of the presented request
//   fetch_ack        fetch -> arbiter  fetch accepts the presented request
//
// Modports:
//   master  arbiter side (drives valid/wfid, samples ack)
//   slave   fetch side   (samples valid/wfid, drives ack)
// -----------------------------------------------------------------------------
interface wave_fetch_request_arbiter_if #(
  parameter int WFID_W = 6
);
  logic              fetch_req_valid;
  logic [WFID_W-1:0] fetch_req_wfid;
  logic              fetch_ack;

  modport master (
    output fetch_req_valid,
    output fetch_req_wfid,
    input  fetch_ack
  );

  modport slave (
    input  fetch_req_valid,
    input  fetch_req_wfid,
    output fetch_ack
  );
endinterface

// File: rtl/wave_fetch_request_arbiter.sv
// -----------------------------------------------------------------------------
// wave_fetch_request_arbiter
//
// Purpose: collects one-cycle "fetch next instruction" pulses per wavefront
//          into a pending bitmap and grants them one at a time, round-robin,
//          to the instruction fetch unit over a valid/ack handshake. A pulse
//          that arrives while fetch is busy is held until it is granted.
//
// Parameters:
//   NUM_WF   wavefronts per CU (default 40)
//   WFID_W   wavefront id width (default 6)
//
// Ports:
//   clk                 in   clock, rising edge
//   rst                 in   synchronous reset, active-low
//   wave_valid_entries  in   [NUM_WF] fetch request pulses from issue flow control
//   wf_kill             in   [NUM_WF] per-wavefront flush
//   pending_bitmap      out  [NUM_WF] registered pending requests (debug/tracemon)
//   fetch_if            master modport: fetch_req_valid, fetch_req_wfid, fetch_ack
//   perf_grant_cnt      out  [32] accepted grants, saturating (optional)
//   perf_stall_cnt      out  [32] cycles with valid & !ack, saturating (optional)
//
// Build option:
//   FETCH_ARB_PERF_CNT_EN  when defined, adds the two performance counters.
//
// All outputs are registered; nothing combinational reaches an output port.
// -----------------------------------------------------------------------------
module wave_fetch_request_arbiter #(
  parameter int NUM_WF = 40,
  parameter int WFID_W = 6
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_WF-1:0]         wave_valid_entries,
  input  logic [NUM_WF-1:0]         wf_kill,
  output logic [NUM_WF-1:0]         pending_bitmap,
`ifdef FETCH_ARB_PERF_CNT_EN
  output logic [31:0]               perf_grant_cnt,
  output logic [31:0]               perf_stall_cnt,
`endif
  wave_fetch_request_arbiter_if.master fetch_if
);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_REQ  = 1'b1
  } state_e;

  state_e            state_q;
  logic              valid_q;
  logic [WFID_W-1:0] wfid_q;
  logic [WFID_W-1:0] last_wf_q;
  logic [NUM_WF-1:0] pending_q;
  logic [NUM_WF-1:0] pending_d;

  logic              accept;
  logic              kill_presented;
  logic [NUM_WF-1:0] accepted_mask;
  logic [NUM_WF-1:0] candidates;
  logic [WFID_W-1:0] search_ptr;
  int                search_start;
  logic              found;
  logic              found_hi;
  logic [WFID_W-1:0] win_hi;
  logic [WFID_W-1:0] win_lo;
  logic [WFID_W-1:0] winner;

  // ---------------------------------------------------------------------------
  // Pending update and round-robin winner search
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every variable gets a default before any conditional assignment so
    // no path leaves it unassigned and no latch is inferred.
    accept         = valid_q & fetch_if.fetch_ack;
    accepted_mask  = '0;
    kill_presented = 1'b0;
    pending_d      = pending_q;
    found_hi       = 1'b0;
    win_hi         = '0;
    win_lo         = '0;

    for (int i = 0; i < NUM_WF; i++) begin
      if (wfid_q == WFID_W'(i)) begin
        accepted_mask[i] = accept;
        kill_presented   = wf_kill[i];
      end
    end

    // Kill beats a new pulse, a new pulse beats the accept clear.
    for (int i = 0; i < NUM_WF; i++) begin
      if (wf_kill[i])                 pending_d[i] = 1'b0;
      else if (wave_valid_entries[i]) pending_d[i] = 1'b1;
      else if (accepted_mask[i])      pending_d[i] = 1'b0;
    end

    // The wf being accepted right now is never re-granted in the same step,
    // and the search starts just after it so back-to-back grants rotate.
    candidates = pending_q & ~wf_kill & ~accepted_mask;
    search_ptr = accept ? wfid_q : last_wf_q;

    // Wrap at NUM_WF rather than at 2^WFID_W.
    if (int'(search_ptr) >= NUM_WF - 1) search_start = 0;
    else                                search_start = int'(search_ptr) + 1;

    // Two-pass priority search: first set bit at or above the start, else the
    // lowest set bit overall (the wrapped part of the ring).
    for (int i = NUM_WF - 1; i >= 0; i--) begin
      if (candidates[i]) begin
        win_lo = WFID_W'(i);
        if (i >= search_start) begin
          found_hi = 1'b1;
          win_hi   = WFID_W'(i);
        end
      end
    end

    found  = |candidates;
    winner = found_hi ? win_hi : win_lo;
  end

  // ---------------------------------------------------------------------------
  // State, pointer and output FSM
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (!rst) begin
      // NOTE: the pending bitmap is ordinary state, not a memory, so it is
      // cleared with everything else; outstanding requests are dropped.
      state_q   <= ST_IDLE;
      valid_q   <= 1'b0;
      wfid_q    <= '0;
      last_wf_q <= WFID_W'(NUM_WF - 1);
      pending_q <= '0;
    end else begin
      pending_q <= pending_d;
      if (accept) last_wf_q <= wfid_q;

      case (state_q)
        ST_IDLE: begin
          if (found) begin
            state_q <= ST_REQ;
            valid_q <= 1'b1;
            wfid_q  <= winner;
          end
        end
        ST_REQ: begin
          // Only an accept or a kill of the presented wf may move the request;
          // otherwise valid and wfid stay put.
          if (accept || kill_presented) begin
            if (found) begin
              wfid_q <= winner;
            end else begin
              state_q <= ST_IDLE;
              valid_q <= 1'b0;
            end
          end
        end
        default: begin
          state_q <= ST_IDLE;
          valid_q <= 1'b0;
        end
      endcase
    end
  end

`ifdef FETCH_ARB_PERF_CNT_EN
  // ---------------------------------------------------------------------------
  // Saturating performance counters
  // ---------------------------------------------------------------------------
  logic [31:0] grant_cnt_q;
  logic [31:0] stall_cnt_q;

  always_ff @(posedge clk) begin
    if (!rst) begin
      grant_cnt_q <= '0;
      stall_cnt_q <= '0;
    end else begin
      if (accept && (grant_cnt_q != '1))
        grant_cnt_q <= grant_cnt_q + 32'd1;
      if (valid_q && !fetch_if.fetch_ack && (stall_cnt_q != '1))
        stall_cnt_q <= stall_cnt_q + 32'd1;
    end
  end

  assign perf_grant_cnt = grant_cnt_q;
  assign perf_stall_cnt = stall_cnt_q;
`endif

  assign fetch_if.fetch_req_valid = valid_q;
  assign fetch_if.fetch_req_wfid  = wfid_q;
  assign pending_bitmap           = pending_q;

endmodule

// File: tb/tb_wave_fetch_request_arbiter.sv
// -----------------------------------------------------------------------------
// tb_wave_fetch_request_arbiter
//
// Self-checking bench for wave_fetch_request_arbiter. Expected grant ids are
// pushed into a queue when the request pulses are driven; a negedge monitor
// pops one entry per accepted handshake and compares the presented wfid.
// A table of pulse patterns (ack held high) exercises round-robin ordering
// and wrap; hand-written sequences cover stall, kill, same-cycle re-pulse,
// kill+ack, reset mid-handshake and, when built with FETCH_ARB_PERF_CNT_EN,
// the performance counters.
// -----------------------------------------------------------------------------
module tb_wave_fetch_request_arbiter;

  localparam int NUM_WF = 40;
  localparam int WFID_W = 6;
  localparam logic [NUM_WF-1:0] ONE = {{(NUM_WF-1){1'b0}}, 1'b1};

  logic              clk;
  logic              rst;
  logic [NUM_WF-1:0] wave_valid_entries;
  logic [NUM_WF-1:0] wf_kill;
  logic [NUM_WF-1:0] pending_bitmap;
`ifdef FETCH_ARB_PERF_CNT_EN
  logic [31:0]       perf_grant_cnt;
  logic [31:0]       perf_stall_cnt;
`endif

  wave_fetch_request_arbiter_if #(.WFID_W(WFID_W)) fetch_if ();

  wave_fetch_request_arbiter #(
    .NUM_WF (NUM_WF),
    .WFID_W (WFID_W)
  ) dut (
    .clk                (clk),
    .rst                (rst),
    .wave_valid_entries (wave_valid_entries),
    .wf_kill            (wf_kill),
    .pending_bitmap     (pending_bitmap),
`ifdef FETCH_ARB_PERF_CNT_EN
    .perf_grant_cnt     (perf_grant_cnt),
    .perf_stall_cnt     (perf_stall_cnt),
`endif
    .fetch_if           (fetch_if.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp  = 0;
  int n_fail = 0;
  int exp_q[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [NUM_WF-1:0] bit_of(input int i);
    return ONE << i;
  endfunction

  // Advance to just after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst                = 1'b0;
    wave_valid_entries = '0;
    wf_kill            = '0;
    fetch_if.fetch_ack = 1'b0;
    step();
    step();
    check("reset_valid",   {63'd0, fetch_if.fetch_req_valid}, 64'd0);
    check("reset_wfid",    {58'd0, fetch_if.fetch_req_wfid}, 64'd0);
    check("reset_pending", {24'd0, pending_bitmap}, 64'd0);
    rst = 1'b1;
  endtask

  // Scoreboard: one pop per accepted handshake, sampled mid-cycle.
  always @(negedge clk) begin
    if (rst && fetch_if.fetch_req_valid && fetch_if.fetch_ack) begin
      check("grant_expected", {63'd0, exp_q.size() > 0}, 64'd1);
      if (exp_q.size() > 0)
        check("grant_wfid", {58'd0, fetch_if.fetch_req_wfid}, 64'(exp_q.pop_front()));
    end
  end

  // Pulse pattern with ack held high and the grant order it must produce.
  typedef struct {
    int n;
    int a;
    int b;
    int c;
    int d;
  } vec_t;

  function automatic int pick(input vec_t v, input int k);
    case (k)
      0:       return v.a;
      1:       return v.b;
      2:       return v.c;
      default: return v.d;
    endcase
  endfunction

  function automatic vec_t mk(input int n, input int a, input int b, input int c, input int d);
    vec_t v;
    v.n = n; v.a = a; v.b = b; v.c = c; v.d = d;
    return v;
  endfunction

  vec_t vecs[6];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [NUM_WF-1:0] mask;

    // Grant order assumes the pointer carried over from the previous row;
    // the first row runs straight after reset (pointer = 39, search from 0).
    vecs[0] = mk(3, 0, 3, 39, 0);    // from 0: 0, 3, 39
    vecs[1] = mk(1, 5, 0, 0, 0);     // from 0 (wrap after 39): 5
    vecs[2] = mk(3, 10, 20, 2, 0);   // from 6: 10, 20, wrap 2
    vecs[3] = mk(3, 3, 1, 2, 0);     // from 3: 3, wrap 1, 2
    vecs[4] = mk(4, 37, 38, 39, 0);  // from 3: 37, 38, 39, wrap 0
    vecs[5] = mk(2, 1, 0, 0, 0);     // from 1: 1, wrap 0

    do_reset();

    // ---------------- table-driven round-robin ----------------
    for (int v = 0; v < 6; v++) begin
      mask = '0;
      for (int k = 0; k < vecs[v].n; k++) begin
        mask |= bit_of(pick(vecs[v], k));
        exp_q.push_back(pick(vecs[v], k));
      end
      wave_valid_entries = mask;
      fetch_if.fetch_ack = 1'b1;
      step();
      wave_valid_entries = '0;
      check("tbl_pending_set", {24'd0, pending_bitmap}, {24'd0, mask});
      check("tbl_valid_latency", {63'd0, fetch_if.fetch_req_valid}, 64'd0);
      for (int k = 0; k < vecs[v].n; k++) begin
        step();
        check("tbl_valid_b2b", {63'd0, fetch_if.fetch_req_valid}, 64'd1);
      end
      step();
      check("tbl_valid_done", {63'd0, fetch_if.fetch_req_valid}, 64'd0);
      check("tbl_pending_done", {24'd0, pending_bitmap}, 64'd0);
    end
    fetch_if.fetch_ack = 1'b0;

    // ---------------- stall: wfid held stable, accepted once ----------------
    do_reset();
    wave_valid_entries = bit_of(7);
    step();
    wave_valid_entries = '0;
    step();
    for (int k = 0; k < 5; k++) begin
      check("stall_valid", {63'd0, fetch_if.fetch_req_valid}, 64'd1);
      check("stall_wfid",  {58'd0, fetch_if.fetch_req_wfid}, 64'd7);
      step();
    end
    fetch_if.fetch_ack = 1'b1;
    exp_q.push_back(7);
    step();
    fetch_if.fetch_ack = 1'b0;
    check("stall_valid_after", {63'd0, fetch_if.fetch_req_valid}, 64'd0);
    check("stall_pending_after", {24'd0, pending_bitmap}, 64'd0);

    // ---------------- kill retracts presented wf ----------------
    do_reset();
    wave_valid_entries = bit_of(7);
    step();
    wave_valid_entries = '0;
    step();
    check("kill_pre_wfid", {58'd0, fetch_if.fetch_req_wfid}, 64'd7);
    wave_valid_entries = bit_of(9);
    step();
    wave_valid_entries = '0;
    check("kill_hold_wfid", {58'd0, fetch_if.fetch_req_wfid}, 64'd7);
    wf_kill = bit_of(7);
    step();
    wf_kill = '0;
    check("kill_valid", {63'd0, fetch_if.fetch_req_valid}, 64'd1);
    check("kill_new_wfid", {58'd0, fetch_if.fetch_req_wfid}, 64'd9);
    check("kill_pending", {24'd0, pending_bitmap}, {24'd0, bit_of(9)});
    fetch_if.fetch_ack = 1'b1;
    exp_q.push_back(9);
    step();
    fetch_if.fetch_ack = 1'b0;
    check("kill_idle", {63'd0, fetch_if.fetch_req_valid}, 64'd0);

    // ---------------- re-pulse in accept cycle, wrap to wf 0 ----------------
    do_reset();
    wave_valid_entries = bit_of(39);
    step();
    wave_valid_entries = '0;
    step();
    check("wrap_first_wfid", {58'd0, fetch_if.fetch_req_wfid}, 64'd39);
    wave_valid_entries = bit_of(0);
    step();
    wave_valid_entries = bit_of(39);
    fetch_if.fetch_ack = 1'b1;
    exp_q.push_back(39);
    exp_q.push_back(0);
    exp_q.push_back(39);
    step();
    wave_valid_entries = '0;
    check("wrap_wfid0", {58'd0, fetch_if.fetch_req_wfid}, 64'd0);
    check("wrap_pending_both", {24'd0, pending_bitmap}, {24'd0, bit_of(0) | bit_of(39)});
    step();
    check("wrap_wfid39", {58'd0, fetch_if.fetch_req_wfid}, 64'd39);
    check("wrap_pending_39", {24'd0, pending_bitmap}, {24'd0, bit_of(39)});
    step();
    fetch_if.fetch_ack = 1'b0;
    check("wrap_idle", {63'd0, fetch_if.fetch_req_valid}, 64'd0);
    check("wrap_pending_done", {24'd0, pending_bitmap}, 64'd0);

    // ---------------- kill and ack together on presented wf ----------------
    do_reset();
    wave_valid_entries = bit_of(4);
    step();
    wave_valid_entries = '0;
    step();
    check("killack_wfid", {58'd0, fetch_if.fetch_req_wfid}, 64'd4);
    fetch_if.fetch_ack = 1'b1;
    wf_kill            = bit_of(4);
    exp_q.push_back(4);
    step();
    fetch_if.fetch_ack = 1'b0;
    wf_kill            = '0;
    check("killack_idle", {63'd0, fetch_if.fetch_req_valid}, 64'd0);
    check("killack_pending", {24'd0, pending_bitmap}, 64'd0);

    // ---------------- reset mid-handshake drops the request ----------------
    wave_valid_entries = bit_of(6);
    step();
    wave_valid_entries = '0;
    step();
    check("midrst_pre_valid", {63'd0, fetch_if.fetch_req_valid}, 64'd1);
    do_reset();
    step();
    step();
    check("midrst_stays_idle", {63'd0, fetch_if.fetch_req_valid}, 64'd0);

`ifdef FETCH_ARB_PERF_CNT_EN
    // ---------------- performance counters ----------------
    do_reset();
    check("perf_grant_reset", {32'd0, perf_grant_cnt}, 64'd0);
    check("perf_stall_reset", {32'd0, perf_stall_cnt}, 64'd0);
    wave_valid_entries = bit_of(1) | bit_of(2);
    step();
    wave_valid_entries = '0;
    step();
    step();
    step();
    step();
    fetch_if.fetch_ack = 1'b1;
    exp_q.push_back(1);
    exp_q.push_back(2);
    step();
    step();
    fetch_if.fetch_ack = 1'b0;
    check("perf_grant_cnt", {32'd0, perf_grant_cnt}, 64'd2);
    check("perf_stall_cnt", {32'd0, perf_stall_cnt}, 64'd3);
`endif

    step();
    check("scoreboard_drained", 64'(exp_q.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/wave_fetch_request_arbiter.md
# wave_fetch_request_arbiter

Accumulates per-wavefront "fetch the next instruction" requests from the issue flow-control stage (`wave_valid_entries`). It grants them one at a time, round-robin, to the instruction fetch unit over a valid/ack handshake. It sits between issue flow control and fetch, so a one-cycle request pulse is never lost while fetch is busy.

## Interface
**Parameters**
- `NUM_WF`, default 40: wavefronts per CU; matches `` `WF_PER_CU ``.
- `WFID_W`, default 6: wavefront id width; matches `` `WF_ID_LENGTH ``.

**Ports** (one clock; reset is synchronous and active-low)
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  synchronous reset, active-low.
- `wave_valid_entries`  in  NUM_WF  per-wavefront fetch request pulses from issue flow control.
- `wf_kill`  in  NUM_WF  per-wavefront flush (wavefront halted or ended).
- `fetch_ack`  in  1  fetch accepts the presented request this cycle.
- `fetch_req_valid`  out  1  request presented.
- `fetch_req_wfid`  out  WFID_W  wavefront id of the presented request.
- `pending_bitmap`  out  NUM_WF  registered pending requests, for debug and tracemon.

## Operation
**Pending register (NUM_WF bits)**
- Next value per bit i, in priority order:
  - `wf_kill[i]` → 0.
  - else `wave_valid_entries[i]` → 1.
  - else (accept && wfid==i) → 0.
  - else hold.
- accept = `fetch_req_valid & fetch_ack`.
- Multiple pulses for the same wf while pending coalesce into one request.
- A new pulse in the accept cycle keeps the bit set; the wf is requested again later.

**Round-robin pointer `last_wf` (WFID_W bits)**
- Reset value is NUM_WF-1, so the first search starts at wf 0.
- Loaded with `fetch_req_wfid` on accept.
- Winner = first set bit of the candidates, searched from (`last_wf`+1) mod NUM_WF upward with wrap.
  - Candidates = pending & ~`wf_kill` & ~(accepted wf mask).
  - If an accept happens this cycle, the search uses the accepted wfid as the pointer.
- Index arithmetic wraps at NUM_WF, not 2^WFID_W. Ids ≥ NUM_WF are never produced.

**Output FSM: IDLE (valid=0), REQ (valid=1)**
- IDLE → REQ when any candidate exists; the winner is loaded into `fetch_req_wfid`.
- REQ, no ack, no kill of the presented wf → stay in REQ. `fetch_req_wfid` is held stable.
- REQ, accept:
  - Another candidate exists → stay in REQ with the new winner (back-to-back).
  - No candidate → IDLE.
- REQ, `wf_kill[fetch_req_wfid]` without ack → request retracted. Go to REQ with another winner, or to IDLE if none. Kill is the only legal retraction.
- Kill and ack in the same cycle for the presented wf: the accept counts; the pending bit clears (kill wins).

**Reset (`rst`=0 at an edge)**
- `pending_bitmap`=0, `fetch_req_valid`=0, `fetch_req_wfid`=0, `last_wf`=NUM_WF-1, FSM=IDLE.
- Reset mid-handshake drops the request. Pending requests are lost; the upstream scheduler reinitialises wavefronts after reset.

## Timing
- `wave_valid_entries[i]` pulse in cycle N → pending bit visible in N+1 → `fetch_req_valid` with wfid i in N+2 when idle and unopposed.
- Throughput is one grant per cycle while `fetch_ack` is held high and candidates exist.
- All outputs are registered; there is no combinational path from inputs to outputs.
- `wf_kill` in cycle N takes effect in N+1: the pending bit is clear and the request is retracted.
- Fairness: a pending wf is granted within NUM_WF accepts.

## Configuration
**`FETCH_ARB_PERF_CNT_EN`**
- Defined: adds the outputs `perf_grant_cnt[31:0]` and `perf_stall_cnt[31:0]`.
  - `perf_grant_cnt` increments on accept.
  - `perf_stall_cnt` increments on cycles with valid & !ack.
  - Both saturate at 0xFFFF_FFFF and reset to 0.
- Undefined: neither port nor its logic exists; all other behaviour is identical.

## Test plan
- Reset, then pulse wf 5 in cycle 10 with `fetch_ack`=1 → valid in cycle 12, wfid=5, one cycle only; `pending_bitmap` returns to 0.
- Pulse wfs 0, 3 and 39 together with ack held 1 → grants 0, 3, 39 on consecutive cycles, then valid=0.
- Pulse wf 7 with ack held 0 for 5 cycles → valid and wfid=7 stable for all 5 cycles; ack in cycle 6 → accepted once.
- wf 7 presented without ack, `wf_kill[7]` asserted, wf 9 pending → next cycle wfid=9, bit 7 clear.
- Grant wf 39, then pulse wf 39 again in the accept cycle, with wf 0 pending → next grant wf 0 (wrap), then wf 39.
- With `FETCH_ARB_PERF_CNT_EN`: 3 stall cycles then 2 accepts → `perf_stall_cnt`=3, `perf_grant_cnt`=2.
